// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, limits and saturating adder for the systolic PE
package systolic_pkg;

    typedef enum logic {
        PE_MODE_WS  = 1'b0,
        PE_MODE_ACC = 1'b1
    } pe_mode_e;

    localparam int PE_DATA_WIDTH = 8;
    localparam int PE_ACC_WIDTH  = 16;
    localparam logic signed [PE_ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(PE_ACC_WIDTH-1){1'b1}}};
    localparam logic signed [PE_ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(PE_ACC_WIDTH-1){1'b0}}};

    // Operands arrive sign-extended to 64 bits; result is {clipped, sum}, caller keeps the low width bits.
    function automatic logic [64:0] sat_add(
        input logic signed [63:0] x,
        input logic signed [63:0] y,
        input int unsigned        width,
        input logic               sat_en
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = x + y;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat_en && (s > hi)) return {1'b1, hi};
        if (sat_en && (s < lo)) return {1'b1, lo};
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/systolic_pe_db_weight_buf.sv
// rtl/systolic_pe_db_weight_buf.sv - shadow/active weight double buffer
module pe_weight_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] w_in,
    input  logic                         w_load,
    input  logic                         w_swap,
    output logic signed [DATA_WIDTH-1:0] active_w
);

    logic signed [DATA_WIDTH-1:0] shadow_w;

    // Swap reads the pre-edge shadow, so load+swap together promotes the old shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_w <= '0;
            active_w <= '0;
        end else begin
            if (w_load) shadow_w <= w_in;
            if (w_swap) active_w <= shadow_w;
        end
    end

endmodule

// File: rtl/systolic_pe_db.sv
// rtl/systolic_pe_db.sv - double-buffered weight-stationary PE with local-accumulate mode
module systolic_pe_db
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode_i,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic                         a_valid_in,
    output logic signed [DATA_WIDTH-1:0] a_out,
    output logic                         a_valid_out,
    input  logic signed [ACC_WIDTH-1:0]  psum_in,
    input  logic                         psum_valid_in,
    output logic signed [ACC_WIDTH-1:0]  psum_out,
    output logic                         psum_valid_out,
    input  logic signed [DATA_WIDTH-1:0] w_in,
    input  logic                         w_load,
    input  logic                         w_swap,
    input  logic                         acc_clr,
    input  logic                         drain,
    output logic                         sat_flag
);

    if (ACC_WIDTH < 2 * DATA_WIDTH || ACC_WIDTH > 62) begin : g_width_check
        $error("systolic_pe_db: ACC_WIDTH must be in [2*DATA_WIDTH, 62]");
    end

    pe_mode_e                            mode;
    logic signed [DATA_WIDTH-1:0]        active_w;
    logic signed [2*DATA_WIDTH-1:0]      prod_full;
    logic signed [ACC_WIDTH-1:0]         prod_q;
    logic signed [ACC_WIDTH-1:0]         psum_q;
    logic                                v1;
    logic signed [ACC_WIDTH-1:0]         acc;
    logic [64:0]                         add_ws;
    logic [64:0]                         add_acc;
    logic signed [ACC_WIDTH-1:0]         acc_sum;
    logic signed [ACC_WIDTH-1:0]         acc_next;
    logic                                clip;

    assign mode      = pe_mode_e'(mode_i);
    assign prod_full = a_in * active_w;

    pe_weight_buf #(.DATA_WIDTH(DATA_WIDTH)) u_weight_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_in     (w_in),
        .w_load   (w_load),
        .w_swap   (w_swap),
        .active_w (active_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
            prod_q      <= '0;
            psum_q      <= '0;
            v1          <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
            prod_q      <= ACC_WIDTH'(prod_full);
            psum_q      <= psum_in;
            v1          <= a_valid_in & (mode_i | psum_valid_in);
        end
    end

    always_comb begin
        add_ws   = sat_add(64'(psum_q), 64'(prod_q), ACC_WIDTH, SATURATE);
        add_acc  = sat_add(64'(acc), 64'(prod_q), ACC_WIDTH, SATURATE);
        acc_sum  = v1 ? ACC_WIDTH'(add_acc[63:0]) : acc;
        clip     = v1 & ((mode == PE_MODE_WS) ? add_ws[64] : add_acc[64]);
        acc_next = acc;
        // Drain empties the accumulator; otherwise clear outranks a same-cycle product.
        if (mode == PE_MODE_ACC && drain) acc_next = '0;
        else if (acc_clr)                 acc_next = '0;
        else if (mode == PE_MODE_ACC)     acc_next = acc_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc            <= '0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            sat_flag       <= 1'b0;
        end else begin
            acc <= acc_next;
            if (acc_clr)   sat_flag <= 1'b0;
            else if (clip) sat_flag <= 1'b1;
            if (mode == PE_MODE_WS) begin
                psum_valid_out <= v1;
                if (v1) psum_out <= ACC_WIDTH'(add_ws[63:0]);
            end else if (drain) begin
                psum_out       <= acc_sum;
                psum_valid_out <= 1'b1;
            end else begin
                psum_out       <= psum_in;
                psum_valid_out <= psum_valid_in;
            end
        end
    end

endmodule
